rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one N:1 data mux (mux8_1-style datapath) between N requesters.
- Grants whole packets: a grant is held until the owner's beat flagged `last` is accepted.
- Drives the mux select and a one-hot grant, and presents the selected stream on a valid/ready output port.
- Sits between N producer blocks and a single downstream consumer.

Parameters:
- N, 8, number of requesters (2..16).
- DATA_W, 1, data bits per requester. Default matches the 1-bit mux datapath.
- SEL_W, $clog2(N), select width. Derived; not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N  per-requester valid.
- req_last  in  N  per-requester last-beat flag; qualified by req.
- req_data  in  N*DATA_W  requester i data at bits [i*DATA_W +: DATA_W].
- ack  out  N  per-requester ready; ack[i] = gnt[i] & out_ready & (state==GRANT).
- out_valid  out  1  selected requester has a beat.
- out_data  out  DATA_W  muxed data.
- out_last  out  1  muxed last flag.
- out_ready  in  1  downstream ready.
- sel  out  SEL_W  registered mux select (index of owner).
- gnt  out  N  registered one-hot grant; all-zero when idle.
- busy  out  1  high in GRANT state.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, gnt=0, sel=0, rr_ptr=0, busy=0. Consequently out_valid=0 and ack=0.
- rst mid-packet aborts the grant immediately. No beat is accepted in the reset cycle.
- States: IDLE, GRANT.
- IDLE: if |req, choose the winner as the first set req bit scanning from rr_ptr upward, wrapping mod N.
  - Register sel=winner and gnt=1<<winner; next state GRANT.
  - Arbitration latency: 1 cycle from req seen to gnt valid.
  - If req==0, stay in IDLE.
- GRANT:
  - out_valid = req[sel]; out_data = req_data[sel*DATA_W +: DATA_W]; out_last = req_last[sel]. All combinational from sel.
  - A beat transfers when out_valid & out_ready.
  - Transfer with out_last=1: rr_ptr <= (sel+1) mod N, gnt <= 0, state -> IDLE. This gives one bubble cycle between packets.
  - Transfer with out_last=0: hold the grant.
- Owner deasserts req mid-packet: grant held, out_valid=0, no timeout.
- Non-owner req is ignored while in GRANT; its ack stays 0.
- out_ready low: hold everything. out_data tracks the owner's live data (requesters must hold data while req & !ack).
- Single-beat packet (req & req_last together): GRANT lasts exactly one cycle if out_ready=1.
- Wrap-around: sel=N-1 finishing sets rr_ptr=0.
- Fairness: with all N requesting continuously, grants cycle in order 0,1,…,N-1,0.
- sel holds its last value in IDLE (not reset to 0) so the mux input stays stable. gnt=0 in IDLE.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: the winner is the lowest-index set req bit. rr_ptr is removed/ignored. All other behaviour, including packet hold and the bubble, is unchanged.
- Undefined: round-robin as above.

Decomposition:
- Package rr_mux_arbiter_pkg holds:
  - state enum {IDLE, GRANT}, 1 bit.
  - function rr_pick(req, ptr) returning index plus a found flag.
- Natural sub-module rr_pick_n: a combinational rotating priority encoder (rotate req by ptr, priority-encode, add ptr mod N).
  - Under ARB_FIXED_PRIO_EN it is instantiated with ptr tied to 0.
- The data mux is an inline indexed part-select; no separate instance.

Test Plan:
1. Reset: rst=1 for 2 cycles with req=8'hFF -> gnt=0, busy=0, out_valid=0, ack=0. The first grant after release is sel=0 one cycle later.
2. Round-robin fairness: req=8'hFF, each 1-beat packet, out_ready=1 -> gnt sequence 0x01,0x02,…,0x80,0x01, each separated by one IDLE cycle.
3. Packet hold: req[2] 3-beat packet (last on beat 3), req[5] asserted meanwhile -> gnt=0x04 for 3 transfers. Then IDLE, then gnt=0x20. No ack[5] during the req[2] packet.
4. Backpressure: owner sel=3, req_data[3]=1, out_ready low 4 cycles then high -> out_valid=1 and ack[3]=0 throughout the stall. Exactly one transfer when out_ready rises.
5. Mid-packet reset and req drop:
   - Owner 6 drops req for 2 cycles mid-packet -> out_valid=0, gnt stays 0x40.
   - Then rst=1 -> next cycle gnt=0, rr_ptr=0.
6. ARB_FIXED_PRIO_EN build: req=8'b1010_0100 repeatedly with 1-beat packets -> always gnt=0x04 while req[2] is held.

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// rr_mux_arbiter_pkg
// Shared types and the round-robin pick function used by the arbiter.
//   state_t  : arbiter FSM state (IDLE / GRANT), 1 bit
//   pick_t   : result of a pick: found flag plus winner index
//   rr_pick  : first set request bit scanning from ptr upward, wrapping mod n
// Requests are passed padded to MAX_N bits so one function serves every N.
package rr_mux_arbiter_pkg;

    localparam int MAX_N = 16;
    localparam int PTR_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [PTR_W-1:0] idx;
    } pick_t;

    // Walks offsets from the farthest to the nearest so the nearest set bit
    // (lowest rotated position) is the one left in the result.
    function automatic pick_t rr_pick(input logic [MAX_N-1:0] req,
                                      input logic [PTR_W-1:0] ptr,
                                      input int               n);
        pick_t            p;
        logic [PTR_W:0]   cand;
        logic [PTR_W:0]   n_w;
        p    = '0;
        n_w  = n[PTR_W:0];
        cand = '0;
        for (int off = MAX_N - 1; off >= 0; off--) begin
            if (off < n) begin
                cand = {1'b0, ptr} + off[PTR_W:0];
                if (cand >= n_w) begin
                    cand = cand - n_w;
                end
                if (req[cand[PTR_W-1:0]]) begin
                    p.found = 1'b1;
                    p.idx   = cand[PTR_W-1:0];
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// rr_mux_arbiter_if
// Bundles the requester side and the downstream side of the arbiter.
//   req/req_last/req_data : per-requester valid, last flag, packed data
//   ack                   : per-requester ready
//   out_valid/out_data/out_last/out_ready : selected stream to the consumer
//   sel/gnt/busy          : arbitration status
// Modports: slave = arbiter view, master = environment (producers+consumer).
interface rr_mux_arbiter_if #(
    parameter int N      = 8,
    parameter int DATA_W = 1
) ();
    localparam int SEL_W = $clog2(N);

    logic [N-1:0]        req;
    logic [N-1:0]        req_last;
    logic [N*DATA_W-1:0] req_data;
    logic [N-1:0]        ack;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic                out_last;
    logic                out_ready;
    logic [SEL_W-1:0]    sel;
    logic [N-1:0]        gnt;
    logic                busy;

    modport slave (
        input  req, req_last, req_data, out_ready,
        output ack, out_valid, out_data, out_last, sel, gnt, busy
    );

    modport master (
        output req, req_last, req_data, out_ready,
        input  ack, out_valid, out_data, out_last, sel, gnt, busy
    );
endinterface

// File: rtl/rr_mux_arbiter_pick.sv
// rr_pick_n
// Combinational rotating priority encoder: returns the first set req bit at
// or above ptr, wrapping mod N.
//   req   : request vector
//   ptr   : starting index of the scan
//   idx   : winning index (valid when found)
//   found : any request set
module rr_pick_n
    import rr_mux_arbiter_pkg::*;
#(
    parameter int N     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);
    pick_t p;

    always_comb begin
        p     = rr_pick(MAX_N'(req), PTR_W'(ptr), N);
        idx   = SEL_W'(p.idx);
        found = p.found;
    end
endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
// Round-robin packet arbiter sharing one N:1 data mux between N requesters.
// A grant is held until the owner's last beat is accepted; one IDLE bubble
// separates packets.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : rr_mux_arbiter_if.slave (requests, ack, output stream, sel/gnt/busy)
// Build option: define ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority
// (no rotating pointer); default is round-robin.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int N      = 8,
    parameter int DATA_W = 1,
    parameter int SEL_W  = $clog2(N)
) (
    input logic           clk,
    input logic           rst,
    rr_mux_arbiter_if.slave bus
);
    state_t           state;
    logic [N-1:0]     gnt_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] win_idx;
    logic             win_found;
    logic             in_grant;
    logic             xfer;

`ifdef ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [SEL_W-1:0] rr_ptr;
    assign pick_ptr = rr_ptr;
`endif

    rr_pick_n #(.N(N), .SEL_W(SEL_W)) u_pick (
        .req   (bus.req),
        .ptr   (pick_ptr),
        .idx   (win_idx),
        .found (win_found)
    );

    assign in_grant = (state == GRANT);

    // Output stream comes straight from the live inputs of the owner; sel is
    // kept through IDLE so the mux input does not move between packets.
    assign bus.out_valid = in_grant & bus.req[sel_q];
    assign bus.out_data  = bus.req_data[sel_q*DATA_W +: DATA_W];
    assign bus.out_last  = bus.req_last[sel_q];
    assign bus.ack       = gnt_q & {N{bus.out_ready & in_grant}};
    assign bus.sel       = sel_q;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = in_grant;

    assign xfer = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt_q <= '0;
            sel_q <= '0;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        sel_q <= win_idx;
                        gnt_q <= {{(N-1){1'b0}}, 1'b1} << win_idx;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (xfer && bus.out_last) begin
                        gnt_q <= '0;
                        state <= IDLE;
`ifndef ARB_FIXED_PRIO_EN
                        rr_ptr <= (sel_q == SEL_W'(N - 1)) ? '0 : sel_q + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter
// Directed scenarios plus a randomized run against a packet-level reference
// model of the arbiter (owner, pointer, busy flag).
// Build option: ARB_FIXED_PRIO_EN selects the fixed-priority expectations.
module tb_rr_mux_arbiter;
    localparam int N  = 8;
    localparam int DW = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_mux_arbiter_if #(.N(N), .DATA_W(DW)) bus ();
    rr_mux_arbiter #(.N(N), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errs   = 0;
    int checks = 0;

    // Reference model: packet owner, round-robin pointer, busy flag.
    bit m_busy;
    int m_sel;
    int m_ptr;

    function automatic int pick(logic [N-1:0] r);
        int base;
`ifdef ARB_FIXED_PRIO_EN
        base = 0;
`else
        base = m_ptr;
`endif
        for (int k = 0; k < N; k++) begin
            if (r[(base + k) % N]) return (base + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_gnt();
        return m_busy ? (N'(1) << m_sel) : '0;
    endfunction

    task automatic drive(logic [N-1:0] r, logic [N-1:0] l, logic [N*DW-1:0] d, logic rdy);
        bus.req       = r;
        bus.req_last  = l;
        bus.req_data  = d;
        bus.out_ready = rdy;
        #1;
    endtask

    // Advance the model with the inputs currently applied, then one clock.
    task automatic tick();
        int w;
        if (rst) begin
            m_busy = 0; m_sel = 0; m_ptr = 0;
        end else if (!m_busy) begin
            w = pick(bus.req);
            if (w >= 0) begin m_busy = 1; m_sel = w; end
        end else if (bus.req[m_sel] && bus.out_ready && bus.req_last[m_sel]) begin
            m_busy = 0;
            m_ptr  = (m_sel + 1) % N;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive('0, '0, '0, 1'b1);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(8'hFF, 8'hFF, '0, 1'b1);
        tick();
        tick();
        checks++; if (bus.gnt !== 8'h00) begin errs++; $display("FAIL reset_gnt: got %h want 00", bus.gnt); end
        checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.ack !== 8'h00) begin errs++; $display("FAIL reset_ack: got %h want 00", bus.ack); end
        rst = 1'b0;
        #1;
        tick();
        checks++; if (bus.gnt !== 8'h01) begin errs++; $display("FAIL reset_first_gnt: got %h want 01", bus.gnt); end
        checks++; if (bus.sel !== 3'd0) begin errs++; $display("FAIL reset_first_sel: got %0d want 0", bus.sel); end
    endtask

`ifdef ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        do_reset();
        drive(8'b1010_0100, 8'hFF, '0, 1'b1);
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++; if (bus.gnt !== 8'h04) begin errs++; $display("FAIL fixed_gnt[%0d]: got %h want 04", k, bus.gnt); end
            tick();
            checks++; if (bus.gnt !== 8'h00) begin errs++; $display("FAIL fixed_bubble[%0d]: got %h want 00", k, bus.gnt); end
            tick();
        end
    endtask
`else
    task automatic test_fairness();
        logic [N-1:0] want;
        do_reset();
        drive(8'hFF, 8'hFF, '0, 1'b1);
        tick();
        for (int k = 0; k <= N; k++) begin
            want = N'(1) << (k % N);
            checks++; if (bus.gnt !== want) begin errs++; $display("FAIL fair_gnt[%0d]: got %h want %h", k, bus.gnt, want); end
            tick();
            checks++; if (bus.gnt !== 8'h00 || bus.busy !== 1'b0) begin errs++; $display("FAIL fair_bubble[%0d]: gnt %h busy %b want 00/0", k, bus.gnt, bus.busy); end
            tick();
        end
    endtask
`endif

    task automatic test_packet_hold();
        do_reset();
        drive(8'b0010_0100, 8'h00, '0, 1'b1);
        tick();
        for (int b = 1; b <= 3; b++) begin
            drive(8'b0010_0100, (b == 3) ? 8'h04 : 8'h00, '0, 1'b1);
            checks++; if (bus.gnt !== 8'h04) begin errs++; $display("FAIL hold_gnt[%0d]: got %h want 04", b, bus.gnt); end
            checks++; if (bus.ack !== 8'h04) begin errs++; $display("FAIL hold_ack[%0d]: got %h want 04", b, bus.ack); end
            checks++; if (bus.out_last !== (b == 3)) begin errs++; $display("FAIL hold_last[%0d]: got %b want %b", b, bus.out_last, (b == 3)); end
            tick();
        end
        drive(8'b0010_0000, 8'h20, '0, 1'b1);
        checks++; if (bus.gnt !== 8'h00 || bus.busy !== 1'b0) begin errs++; $display("FAIL hold_bubble: gnt %h busy %b want 00/0", bus.gnt, bus.busy); end
        tick();
        checks++; if (bus.gnt !== 8'h20) begin errs++; $display("FAIL hold_next_gnt: got %h want 20", bus.gnt); end
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(8'b0000_1000, 8'b0000_1000, 8'b0000_1000, 1'b0);
        tick();
        for (int c = 0; c < 4; c++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.ack !== 8'h00) begin errs++; $display("FAIL stall[%0d]: valid %b ack %h want 1/00", c, bus.out_valid, bus.ack); end
            checks++; if (bus.out_data !== 1'b1 || bus.gnt !== 8'h08) begin errs++; $display("FAIL stall_data[%0d]: data %b gnt %h want 1/08", c, bus.out_data, bus.gnt); end
            tick();
        end
        drive(8'b0000_1000, 8'b0000_1000, 8'b0000_1000, 1'b1);
        checks++; if (bus.ack !== 8'h08) begin errs++; $display("FAIL bp_ack: got %h want 08", bus.ack); end
        tick();
        drive('0, '0, '0, 1'b1);
        checks++; if (bus.busy !== 1'b0 || bus.gnt !== 8'h00) begin errs++; $display("FAIL bp_done: busy %b gnt %h want 0/00", bus.busy, bus.gnt); end
    endtask

    task automatic test_midpacket();
        do_reset();
        drive(8'b0000_1000, 8'b0000_1000, '0, 1'b1);
        tick();
        tick();
        drive(8'b0100_0000, 8'h00, '0, 1'b1);
        tick();
        checks++; if (bus.gnt !== 8'h40) begin errs++; $display("FAIL mid_gnt: got %h want 40", bus.gnt); end
        tick();
        drive(8'h00, 8'h00, '0, 1'b1);
        for (int c = 0; c < 2; c++) begin
            checks++; if (bus.out_valid !== 1'b0 || bus.gnt !== 8'h40) begin errs++; $display("FAIL mid_drop[%0d]: valid %b gnt %h want 0/40", c, bus.out_valid, bus.gnt); end
            tick();
        end
        rst = 1'b1;
        drive(8'b0100_0000, 8'h00, '0, 1'b1);
        tick();
        rst = 1'b0;
        drive(8'hFF, 8'hFF, '0, 1'b1);
        checks++; if (bus.gnt !== 8'h00 || bus.busy !== 1'b0) begin errs++; $display("FAIL mid_rst: gnt %h busy %b want 00/0", bus.gnt, bus.busy); end
        tick();
        checks++; if (bus.gnt !== 8'h01) begin errs++; $display("FAIL mid_ptr_reset: got %h want 01", bus.gnt); end
    endtask

    task automatic test_random();
        logic [N-1:0] r, l, eg;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            r = N'($urandom) & N'($urandom);
            if ($urandom_range(3, 0) == 0) r = N'($urandom);
            l = '0;
            for (int i = 0; i < N; i++) l[i] = ($urandom_range(2, 0) == 0);
            rst = ($urandom_range(199, 0) == 0);
            drive(r, l, N'($urandom), ($urandom_range(3, 0) != 0));
            eg = exp_gnt();
            checks++; if (bus.gnt !== eg) begin errs++; $display("FAIL rand_gnt[%0d]: got %h want %h", c, bus.gnt, eg); end
            checks++; if (bus.busy !== m_busy) begin errs++; $display("FAIL rand_busy[%0d]: got %b want %b", c, bus.busy, m_busy); end
            checks++; if (bus.sel !== 3'(m_sel)) begin errs++; $display("FAIL rand_sel[%0d]: got %0d want %0d", c, bus.sel, m_sel); end
            checks++; if (bus.out_valid !== (m_busy && r[m_sel])) begin errs++; $display("FAIL rand_valid[%0d]: got %b want %b", c, bus.out_valid, (m_busy && r[m_sel])); end
            checks++; if (bus.ack !== (bus.out_ready ? eg : 8'h00)) begin errs++; $display("FAIL rand_ack[%0d]: got %h want %h", c, bus.ack, (bus.out_ready ? eg : 8'h00)); end
            if (m_busy) begin
                checks++; if (bus.out_data !== bus.req_data[m_sel] || bus.out_last !== l[m_sel]) begin errs++; $display("FAIL rand_mux[%0d]: data %b last %b want %b/%b", c, bus.out_data, bus.out_last, bus.req_data[m_sel], l[m_sel]); end
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        m_busy = 0; m_sel = 0; m_ptr = 0;
        drive('0, '0, '0, 1'b0);
        @(negedge clk);
        test_reset();
`ifdef ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_fairness();
`endif
        test_packet_hold();
        test_backpressure();
        test_midpacket();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
